// File: rtl/trace_stream_arbiter.sv
// trace_stream_arbiter: round-robin arbiter between a register-write (GRF) and
// a memory-write (DM) trace requester, serialising each granted record one
// character per handshake as "^<time>@<pc>: $<reg> <= <data>#" or
// "^<time>@<pc>: *<addr> <= <data>#".
// Optional build macro TRACE_NEWLINE_EN appends a newline character after '#'.
module trace_stream_arbiter #(
   parameter int unsigned TIME_STEP = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        grf_valid,
   output logic        grf_ready,
   input  logic [31:0] grf_pc,
   input  logic [4:0]  grf_reg,
   input  logic [31:0] grf_data,
   input  logic        dm_valid,
   output logic        dm_ready,
   input  logic [31:0] dm_pc,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_data,
   output logic [7:0]  char_out,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        busy
);

   typedef enum logic [4:0] {
      S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_TAG, S_ID,
      S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH, S_NL
   } state_t;

   state_t      r_state, w_next_state;
   logic [2:0]  r_idx, w_next_idx;
   logic        r_is_dm;
   logic        r_last_dm;
   logic [31:0] r_pc, r_id, r_data;
   logic [13:0] r_time;

   logic        w_take, w_done, w_accept;
   logic        w_grant_grf, w_grant_dm;
   logic [3:0]  w_t_d3, w_t_d2, w_t_d1, w_t_d0, w_t_digit;
   logic [1:0]  w_t_start;
   logic [3:0]  w_r_tens, w_r_ones;
   logic        w_r_start;
   logic [14:0] w_time_sum;
   logic [13:0] w_time_next;

   function automatic logic [3:0] nib(input logic [31:0] v, input logic [2:0] i);
      logic [31:0] s;
      s = v << {i, 2'b00};
      return s[31:28];
   endfunction

   function automatic logic [7:0] hex_chr(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   function automatic logic [7:0] dec_chr(input logic [3:0] d);
      return 8'h30 + {4'h0, d};
   endfunction

   // r_last_dm set means DM was served last, so GRF wins a tie
   assign w_grant_grf = grf_valid & (~dm_valid | r_last_dm);
   assign w_grant_dm  = dm_valid & (~grf_valid | ~r_last_dm);
   assign w_accept    = grf_ready | dm_ready;

   assign char_valid  = (r_state != S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign w_take      = char_valid & char_ready;

   assign w_t_d3 = 4'(r_time / 14'd1000);
   assign w_t_d2 = 4'((r_time / 14'd100) % 14'd10);
   assign w_t_d1 = 4'((r_time / 14'd10) % 14'd10);
   assign w_t_d0 = 4'(r_time % 14'd10);
   assign w_t_start = (w_t_d3 != 4'd0) ? 2'd0 :
                      (w_t_d2 != 4'd0) ? 2'd1 :
                      (w_t_d1 != 4'd0) ? 2'd2 : 2'd3;

   assign w_r_tens  = 4'(r_id[4:0] / 5'd10);
   assign w_r_ones  = 4'(r_id[4:0] % 5'd10);
   assign w_r_start = (w_r_tens == 4'd0);

   assign w_time_sum  = {1'b0, r_time} + 15'(TIME_STEP);
   assign w_time_next = (w_time_sum >= 15'd10000) ? 14'(w_time_sum - 15'd10000)
                                                  : w_time_sum[13:0];

   // selected decimal digit of the time stamp (index 0 = thousands)
   always_comb begin
      w_t_digit = w_t_d0;
      case (r_idx[1:0])
         2'd0:    w_t_digit = w_t_d3;
         2'd1:    w_t_digit = w_t_d2;
         2'd2:    w_t_digit = w_t_d1;
         default: w_t_digit = w_t_d0;
      endcase
   end

   // next-state, digit index, character and grant decode
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      char_out     = '0;
      grf_ready    = 1'b0;
      dm_ready     = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            grf_ready = reset & w_grant_grf;
            dm_ready  = reset & w_grant_dm;
            if (w_grant_grf | w_grant_dm) w_next_state = S_CARET;
         end
         S_CARET: begin
            char_out = "^";
            if (w_take) begin
               w_next_state = S_TIME;
               w_next_idx   = {1'b0, w_t_start};
            end
         end
         S_TIME: begin
            char_out = dec_chr(w_t_digit);
            if (w_take) begin
               if (r_idx[1:0] == 2'd3) w_next_state = S_AT;
               else                    w_next_idx   = r_idx + 3'd1;
            end
         end
         S_AT: begin
            char_out = "@";
            if (w_take) begin
               w_next_state = S_PC;
               w_next_idx   = '0;
            end
         end
         S_PC: begin
            char_out = hex_chr(nib(r_pc, r_idx));
            if (w_take) begin
               if (r_idx == 3'd7) w_next_state = S_COLON;
               w_next_idx = r_idx + 3'd1;
            end
         end
         S_COLON: begin
            char_out = ":";
            if (w_take) w_next_state = S_SP1;
         end
         S_SP1: begin
            char_out = " ";
            if (w_take) w_next_state = S_TAG;
         end
         S_TAG: begin
            char_out = r_is_dm ? "*" : "$";
            if (w_take) begin
               w_next_state = S_ID;
               w_next_idx   = r_is_dm ? 3'd0 : {2'b00, w_r_start};
            end
         end
         S_ID: begin
            if (r_is_dm) char_out = hex_chr(nib(r_id, r_idx));
            else         char_out = dec_chr(r_idx[0] ? w_r_ones : w_r_tens);
            if (w_take) begin
               if ((r_is_dm && r_idx == 3'd7) || (!r_is_dm && r_idx == 3'd1)) begin
                  w_next_state = S_SP2;
                  w_next_idx   = '0;
               end else begin
                  w_next_idx = r_idx + 3'd1;
               end
            end
         end
         S_SP2: begin
            char_out = " ";
            if (w_take) w_next_state = S_LT;
         end
         S_LT: begin
            char_out = "<";
            if (w_take) w_next_state = S_EQ;
         end
         S_EQ: begin
            char_out = "=";
            if (w_take) w_next_state = S_SP3;
         end
         S_SP3: begin
            char_out = " ";
            if (w_take) begin
               w_next_state = S_DATA;
               w_next_idx   = '0;
            end
         end
         S_DATA: begin
            char_out = hex_chr(nib(r_data, r_idx));
            if (w_take) begin
               if (r_idx == 3'd7) w_next_state = S_HASH;
               w_next_idx = r_idx + 3'd1;
            end
         end
         S_HASH: begin
            char_out = "#";
`ifdef TRACE_NEWLINE_EN
            if (w_take) w_next_state = S_NL;
`else
            if (w_take) begin
               w_next_state = S_IDLE;
               w_done       = 1'b1;
            end
`endif
         end
`ifdef TRACE_NEWLINE_EN
         S_NL: begin
            char_out = 8'h0A;
            if (w_take) begin
               w_next_state = S_IDLE;
               w_done       = 1'b1;
            end
         end
`endif
         default: w_next_state = S_IDLE;
      endcase
   end

   // state and digit-index register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
      end
   end

   // latch granted fields; update time stamp and pointer at end of record
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_is_dm   <= 1'b0;
         r_last_dm <= 1'b1;
         r_pc      <= '0;
         r_id      <= '0;
         r_data    <= '0;
         r_time    <= '0;
      end else begin
         if (w_accept) begin
            r_is_dm <= dm_ready;
            r_pc    <= dm_ready ? dm_pc   : grf_pc;
            r_id    <= dm_ready ? dm_addr : {27'd0, grf_reg};
            r_data  <= dm_ready ? dm_data : grf_data;
         end
         if (w_done) begin
            r_time    <= w_time_next;
            r_last_dm <= r_is_dm;
         end
      end
   end

endmodule
